regfile_wb_scheduler: RTL

// Shares the register file's single write port between NUM_SRC writeback producers (ALU, load unit,

---
 rtl/regfile_wb_scheduler_pkg.sv | 17 +
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 56 +++++
 rtl/regfile_wb_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths and the writeback payload type for the register-file writeback scheduler.
//   REGISTER_WIDTH : architectural register width
//   REGISTER_DEPTH : architectural register count (x0 hardwired to zero)
//   REG_ADDR_WIDTH : register address width
//   wb_req_t       : one writeback payload (destination + data)
package regfile_wb_scheduler_pkg;

  localparam int unsigned REGISTER_WIDTH = 32;
  localparam int unsigned REGISTER_DEPTH = 32;
  localparam int unsigned REG_ADDR_WIDTH = $clog2(REGISTER_DEPTH);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REGISTER_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter. The grant goes to the first requester at or after the
// pointer (modulo N). When advance is high and a grant exists, the pointer moves
// to the position just after the granted requester; otherwise it holds.
//   clk, rst_n : clock, async active-low reset (pointer -> 0)
//   req        : request vector
//   advance    : the current grant was consumed this cycle
//   grant      : one-hot or zero grant vector (combinational)
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] gidx;
  logic             found;
  int unsigned      idx;

  // Scan starting at the pointer and take the first requester found.
  always_comb begin
    grant = '0;
    gidx  = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr_q) + off) % N;
      if (!found && req[PTR_W'(idx)]) begin
        found                = 1'b1;
        grant[PTR_W'(idx)]   = 1'b1;
        gidx                 = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = PTR_W'((32'(gidx) + 1) % N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler. Shares the single register-file write port
// between NUM_SRC producers with round-robin arbitration and a registered write
// drive, and keeps a per-register pending-write scoreboard for decode hazards.
//   clk, rst                : clock, async active-low reset
//   src_valid/addr/data     : producer requests; src_ready = combinational accept
//   issue_valid/rd/ready    : decode issue of a register-writing instruction (WAW stall)
//   flush                   : clear scoreboard (in-flight write still goes out)
//   rs1/rs2_addr, _busy     : decode source lookups against the scoreboard
//   wr_en/addr/data         : registered register-file write port
// Width parameters must match the package values, since wb_req_t is sized by them.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 3,
  parameter int unsigned REGISTER_WIDTH = regfile_wb_scheduler_pkg::REGISTER_WIDTH,
  parameter int unsigned REGISTER_DEPTH = regfile_wb_scheduler_pkg::REGISTER_DEPTH,
  localparam int unsigned ADDR_W        = $clog2(REGISTER_DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_SRC-1:0]                     src_valid,
  output logic [NUM_SRC-1:0]                     src_ready,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]         src_addr,
  input  logic [NUM_SRC-1:0][REGISTER_WIDTH-1:0] src_data,
  input  logic                                   issue_valid,
  input  logic [ADDR_W-1:0]                      issue_rd,
  output logic                                   issue_ready,
  input  logic                                   flush,
  input  logic [ADDR_W-1:0]                      rs1_addr,
  output logic                                   rs1_busy,
  input  logic [ADDR_W-1:0]                      rs2_addr,
  output logic                                   rs2_busy,
  output logic                                   wr_en,
  output logic [ADDR_W-1:0]                      wr_addr,
  output logic [REGISTER_WIDTH-1:0]              wr_data
);

  logic [NUM_SRC-1:0]        grant;
  logic                      accept;
  wb_req_t                   sel;
  logic                      wr_en_q;
  logic                      wr_en_d;
  wb_req_t                   wr_req_q;
  wb_req_t                   wr_req_d;
  logic [REGISTER_DEPTH-1:0] pending_q;
  logic [REGISTER_DEPTH-1:0] pending_d;
  logic                      issue_fire;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk     (clk),
    .rst_n   (rst),
    .req     (src_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Ready is forced low while reset is asserted so nothing is consumed then.
  assign src_ready = grant & {NUM_SRC{rst}};
  assign accept    = |src_ready;

  // Select the granted producer's payload.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel.addr = src_addr[i];
        sel.data = src_data[i];
      end
    end
  end

  // Writes to x0 are drained from the producer but never reach the register file.
  always_comb begin
    wr_en_d  = accept && (sel.addr != '0);
    wr_req_d = accept ? sel : wr_req_q;
  end

  assign issue_ready = !pending_q[issue_rd] || (issue_rd == '0);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
  assign rs1_busy    = pending_q[rs1_addr] && (rs1_addr != '0);
  assign rs2_busy    = pending_q[rs2_addr] && (rs2_addr != '0);

  // Scoreboard update: flush or commit clears, a new issue sets and wins.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else if (wr_en_q) begin
      pending_d[wr_req_q.addr] = 1'b0;
    end
    if (issue_fire) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_req_q  <= '0;
      pending_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_req_q  <= wr_req_d;
      pending_q <= pending_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_req_q.addr;
  assign wr_data = wr_req_q.data;

endmodule
